// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Ticks per bit period and the tick index treated as mid-bit.
    localparam int OVS        = 16;
    localparam int MID_SAMPLE = 7;

    // parity_type encodings.
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/baud_tick_rx.sv
// 16x oversampling tick generator. restart forces the divider back to 0 so the
// tick phase lines up with a freshly detected start edge.
module baud_tick_rx #(
    parameter int CLK_DIV = 27
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int DIV = (CLK_DIV < 1) ? 1 : CLK_DIV;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(DIV - 1));
    assign tick = wrap && !restart;

    // Next divider count: restart wins, otherwise count and wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (restart || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronizer, 16x oversampled start/data/parity/stop
// decoding, one-cycle rx_valid strobe with parity and framing error flags.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of
// samples at ovs 6, 7 and 8, decided at ovs 8; otherwise a single sample at 7.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int Data_length = 8,
    parameter int parity_en   = 0,
    parameter int fqr         = 50000000,
    parameter int baud_rate   = 115200
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    input  logic                   serial_in,
    input  logic                   parity_type,
    output logic [Data_length-1:0] data_out,
    output logic                   rx_valid,
    output logic                   rx_busy,
    output logic                   parity_err,
    output logic                   frame_err
);

    localparam int CLK_DIV = fqr / (baud_rate * OVS);

    rx_state_e              state_q, state_d;
    logic                   sync1_q, rxs_q, rxs_prev_q;
    logic [3:0]             ovs_q, ovs_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [Data_length-1:0] shift_q, shift_d;
    logic [Data_length-1:0] data_q, data_d;
    logic                   perr_pend_q, perr_pend_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tick, start_edge, sample_point, bit_val;

    assign start_edge = (state_q == IDLE) && rxs_prev_q && !rxs_q;

    baud_tick_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .restart (start_edge),
        .tick    (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic s6_q, s6_d, s7_q, s7_d;
    assign sample_point = tick && (ovs_q == 4'(MID_SAMPLE + 1));
    assign bit_val      = (s6_q & s7_q) | (s6_q & rxs_q) | (s7_q & rxs_q);

    // Capture the two early majority samples.
    always_comb begin
        s6_d = s6_q;
        s7_d = s7_q;
        if (tick && ovs_q == 4'(MID_SAMPLE - 1)) s6_d = rxs_q;
        if (tick && ovs_q == 4'(MID_SAMPLE))     s7_d = rxs_q;
    end

    // Majority sample registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            s6_q <= 1'b1;
            s7_q <= 1'b1;
        end else begin
            s6_q <= s6_d;
            s7_q <= s7_d;
        end
    end
`else
    assign sample_point = tick && (ovs_q == 4'(MID_SAMPLE));
    assign bit_val      = rxs_q;
`endif

    // Next-state, datapath and strobe logic of the receive FSM.
    always_comb begin
        state_d      = state_q;
        ovs_d        = ovs_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        perr_pend_d  = perr_pend_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rx_valid_d   = 1'b0;
        if (tick) ovs_d = ovs_q + 4'd1;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                    ovs_d   = 4'd0;
                end
            end
            START: begin
                if (sample_point) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = 4'd0;
                    end
                end
            end
            DATA: begin
                if (sample_point) begin
                    shift_d = {bit_val, shift_q[Data_length-1:1]};
                    if (bit_cnt_q == 4'(Data_length - 1)) begin
                        state_d     = (parity_en != 0) ? PARITY : STOP;
                        perr_pend_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (sample_point) begin
                    perr_pend_d = bit_val ^ (^shift_q) ^ (parity_type == PARITY_ODD);
                    state_d     = STOP;
                end
            end
            STOP: begin
                if (sample_point) begin
                    data_d       = shift_q;
                    parity_err_d = (parity_en != 0) ? perr_pend_q : 1'b0;
                    frame_err_d  = ~bit_val;
                    rx_valid_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchronizer, FSM and output registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= IDLE;
            ovs_q        <= 4'd0;
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            data_q       <= '0;
            perr_pend_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_valid_q   <= 1'b0;
        end else begin
            sync1_q      <= serial_in;
            rxs_q        <= sync1_q;
            rxs_prev_q   <= rxs_q;
            state_q      <= state_d;
            ovs_q        <= ovs_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            perr_pend_q  <= perr_pend_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_valid_q   <= rx_valid_d;
        end
    end

    assign data_out   = data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_busy    = (state_q != IDLE);
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: an 8N1 instance (A) and an 8-bit parity
// instance (B), each with a scoreboard queue checked on every rx_valid.
module tb_uart_receiver;

    localparam int BIT = 160;   // clk1 cycles per bit (clk_div 10 x 16)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_a = 1'b1, ser_b = 1'b1;
    logic       ptype_a = 1'b0, ptype_b = 1'b0;
    logic [7:0] dout_a, dout_b;
    logic       vld_a, vld_b, busy_a, busy_b, perr_a, perr_b, ferr_a, ferr_b;

    int checks = 0;
    int errors = 0;
    int strobes_a = 0;
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];

    always #5 clk = ~clk;

    uart_receiver #(.Data_length(8), .parity_en(0), .fqr(1600000), .baud_rate(10000)) dut_a (
        .clk1(clk), .rst_n(rst_n), .serial_in(ser_a), .parity_type(ptype_a),
        .data_out(dout_a), .rx_valid(vld_a), .rx_busy(busy_a),
        .parity_err(perr_a), .frame_err(ferr_a));

    uart_receiver #(.Data_length(8), .parity_en(1), .fqr(1600000), .baud_rate(10000)) dut_b (
        .clk1(clk), .rst_n(rst_n), .serial_in(ser_b), .parity_type(ptype_b),
        .data_out(dout_b), .rx_valid(vld_b), .rx_busy(busy_b),
        .parity_err(perr_b), .frame_err(ferr_b));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) ser_a = v; else ser_b = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic stopb, input int spike_bit);
        drive(which, 1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                drive(which, d[i], 82);
                drive(which, ~d[i], 1);
                drive(which, d[i], BIT - 83);
            end else begin
                drive(which, d[i], BIT);
            end
        end
        if (has_par) drive(which, pbit, BIT);
        drive(which, stopb, BIT);
    endtask

    task automatic frame_a(input logic [7:0] d, input logic stopb, input int spike_bit);
        q_a.push_back({d, 1'b0, ~stopb});
        send_frame(0, d, 1'b0, 1'b0, stopb, spike_bit);
        check("strobe_seen_a", 16'(q_a.size()), 16'd0);
        $display("frame A data=%02h stop=%0b", d, stopb);
    endtask

    task automatic frame_b(input logic [7:0] d, input logic pt, input logic pbit);
        logic even_bit;
        logic exp_perr;
        even_bit = ^d;
        exp_perr = (pbit != (pt ? ~even_bit : even_bit));
        ptype_b  = pt;
        q_b.push_back({d, exp_perr, 1'b0});
        send_frame(1, d, 1'b1, pbit, 1'b1, -1);
        check("strobe_seen_b", 16'(q_b.size()), 16'd0);
        $display("frame B data=%02h ptype=%0b pbit=%0b", d, pt, pbit);
    endtask

    initial begin
        logic [9:0] e;
        int snap;
        fork
            forever begin
                @(negedge clk);
                if (vld_a) begin
                    strobes_a++;
                    check("unexpected_strobe_a", 16'(q_a.size() != 0), 16'd1);
                    if (q_a.size() != 0) begin
                        e = q_a.pop_front();
                        check("data_a", 16'(dout_a), 16'(e[9:2]));
                        check("perr_a", 16'(perr_a), 16'(e[1]));
                        check("ferr_a", 16'(ferr_a), 16'(e[0]));
                        check("busy_at_strobe_a", 16'(busy_a), 16'd0);
                    end
                end
                if (vld_b) begin
                    check("unexpected_strobe_b", 16'(q_b.size() != 0), 16'd1);
                    if (q_b.size() != 0) begin
                        e = q_b.pop_front();
                        check("data_b", 16'(dout_b), 16'(e[9:2]));
                        check("perr_b", 16'(perr_b), 16'(e[1]));
                        check("ferr_b", 16'(ferr_b), 16'(e[0]));
                    end
                end
            end
        join_none

        // Reset values.
        repeat (5) @(negedge clk);
        check("rst_data_a", 16'(dout_a), 16'd0);
        check("rst_flags_a", 16'({vld_a, busy_a, perr_a, ferr_a}), 16'd0);
        check("rst_flags_b", 16'({vld_b, busy_b, perr_b, ferr_b}), 16'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 8N1 frame.
        frame_a(8'hA5, 1'b1, -1);
        check("busy_after_a5", 16'(busy_a), 16'd0);

        // Parity frames: even/good, even/bad, odd/good.
        frame_b(8'h03, 1'b0, 1'b0);
        frame_b(8'h03, 1'b0, 1'b1);
        frame_b(8'h03, 1'b1, 1'b1);

        // 3-tick glitch on idle line: busy briefly, no strobe, outputs kept.
        snap = strobes_a;
        drive(0, 1'b0, 30);
        check("glitch_busy", 16'(busy_a), 16'd1);
        drive(0, 1'b1, 200);
        check("glitch_busy_clear", 16'(busy_a), 16'd0);
        check("glitch_no_strobe", 16'(strobes_a), 16'(snap));
        check("glitch_data_kept", 16'(dout_a), 16'hA5);
        $display("glitch test done");

        // Framing error, then a held-low break must not retrigger.
        frame_a(8'h5A, 1'b0, -1);
        snap = strobes_a;
        drive(0, 1'b0, 600);
        check("break_no_strobe", 16'(strobes_a), 16'(snap));
        check("break_not_busy", 16'(busy_a), 16'd0);
        drive(0, 1'b1, BIT);
        $display("break test done");

        // Back-to-back frames.
        frame_a(8'h00, 1'b1, -1);
        frame_a(8'hFF, 1'b1, -1);
        drive(0, 1'b1, BIT);

`ifdef UART_RX_MAJORITY_EN
        frame_a(8'hC6, 1'b1, 3);
        drive(0, 1'b1, BIT);
`endif

        // Reset in the middle of frame 0x77.
        drive(0, 1'b0, BIT);
        for (int i = 0; i < 3; i++) drive(0, 1'(8'h77 >> i), BIT);
        drive(0, 1'b0, 80);
        rst_n = 1'b0;
        #1;
        check("midrst_data_a", 16'(dout_a), 16'd0);
        check("midrst_flags_a", 16'({vld_a, busy_a, perr_a, ferr_a}), 16'd0);
        check("midrst_data_b", 16'(dout_b), 16'd0);
        $display("mid-frame reset applied");
        ser_a = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, BIT);
        frame_a(8'h11, 1'b1, -1);
        repeat (BIT) @(negedge clk);
        check("queue_drained_a", 16'(q_a.size()), 16'd0);
        check("queue_drained_b", 16'(q_b.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
